// File: rtl/cm3_excl_arb.sv
// Round-robin AHB-lite arbiter that keeps the grant on a master between its exclusive read
// and exclusive write. A down-counter releases the lock if the write never arrives.
//
// state  | meaning
// S_IDLE | no master granted
// S_GNT  | grant held by OWNER, re-arbitrated on each accepted transfer
// S_LOCK | grant frozen on OWNER between exclusive read and write
module cm3_excl_arb #(
  parameter int N_MASTERS    = 2,
  parameter int LOCK_TIMEOUT = 128
) (
  input  logic                         CLK,
  input  logic                         RESETn,
  input  logic                         HALTED,
  input  logic [N_MASTERS-1:0]         REQ,
  input  logic [N_MASTERS-1:0]         EXREQ,
  input  logic [N_MASTERS-1:0]         HWRITE_M,
  input  logic                         HREADY,
  output logic [N_MASTERS-1:0]         GRANT,
  output logic [$clog2(N_MASTERS)-1:0] OWNER,
  output logic                         LOCKED,
  output logic                         TIMEOUT
);

  localparam int OW = $clog2(N_MASTERS);
  localparam int CW = $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0]        CNT_LOAD = CW'(LOCK_TIMEOUT - 1);
  localparam logic [N_MASTERS-1:0] ONE_HOT0 = {{(N_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_GNT, S_LOCK} state_t;

  state_t               state, state_n;
  logic [N_MASTERS-1:0] grant_n;
  logic [OW-1:0]        owner_n, rr_ptr, rr_n, win, idx;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 tout_n, found, others_req, exrd, exwr;

  // First requester strictly after rr_ptr, wrapping; the owner itself is searched last.
  always_comb begin
    win   = rr_ptr;
    idx   = rr_ptr;
    found = 1'b0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = OW'((int'(rr_ptr) + i) % N_MASTERS);
      if (!found && REQ[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign others_req = |(REQ & ~(ONE_HOT0 << OWNER));
  assign exrd       = HREADY & EXREQ[OWNER] & ~HWRITE_M[OWNER];
  assign exwr       = HREADY & EXREQ[OWNER] & HWRITE_M[OWNER];

  always_comb begin
    state_n = state;
    grant_n = GRANT;
    owner_n = OWNER;
    rr_n    = rr_ptr;
    tout_n  = 1'b0;
    cnt_n   = (cnt != '0 && !HALTED) ? cnt - CW'(1) : cnt;
    case (state)
      S_IDLE: begin
        if (HREADY && found) begin
          state_n = S_GNT;
          grant_n = ONE_HOT0 << win;
          owner_n = win;
          rr_n    = win;
        end
      end
      S_GNT: begin
        if (exrd) begin
          state_n = S_LOCK;
          cnt_n   = CNT_LOAD;
        end else if (HREADY) begin
          if (others_req) begin
            grant_n = ONE_HOT0 << win;
            owner_n = win;
            rr_n    = win;
          end else if (!REQ[OWNER]) begin
            grant_n = '0;
            state_n = S_IDLE;
          end
        end
      end
      S_LOCK: begin
        // Leaving the lock never moves the grant; re-arbitration waits for the next edge.
        if (exwr) begin
          state_n = S_GNT;
        end else if (HREADY && !REQ[OWNER]) begin
          state_n = S_GNT;
        end else if (exrd) begin
          cnt_n = CNT_LOAD;
        end else if (HREADY && cnt == '0 && !HALTED) begin
          state_n = S_GNT;
          tout_n  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= S_IDLE;
      GRANT   <= '0;
      OWNER   <= '0;
      rr_ptr  <= OW'(N_MASTERS - 1);
      cnt     <= '0;
      LOCKED  <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      state   <= state_n;
      GRANT   <= grant_n;
      OWNER   <= owner_n;
      rr_ptr  <= rr_n;
      cnt     <= cnt_n;
      LOCKED  <= (state_n == S_LOCK);
      TIMEOUT <= tout_n;
    end
  end

endmodule

// File: tb/tb_cm3_excl_arb.sv
// Scoreboard bench for cm3_excl_arb: the driver pushes model predictions per edge,
// and a monitor pops and compares them after each rising edge.
module tb_cm3_excl_arb;
  localparam int N  = 2;
  localparam int LT = 128;
  localparam int OW = $clog2(N);

  logic          CLK = 1'b0;
  logic          RESETn, HALTED, HREADY;
  logic [N-1:0]  REQ, EXREQ, HWRITE_M, GRANT;
  logic [OW-1:0] OWNER;
  logic          LOCKED, TIMEOUT;

  cm3_excl_arb #(.N_MASTERS(N), .LOCK_TIMEOUT(LT)) dut (
    .CLK(CLK), .RESETn(RESETn), .HALTED(HALTED), .REQ(REQ), .EXREQ(EXREQ),
    .HWRITE_M(HWRITE_M), .HREADY(HREADY), .GRANT(GRANT), .OWNER(OWNER),
    .LOCKED(LOCKED), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0] grant;
    int           owner;
    bit           locked;
    bit           tout;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   lock_run = 0, last_lock_len = 0, tout_count = 0;

  // reference model state: who holds the bus, whether it is locked, cycles left
  bit m_granted, m_locked, m_tout;
  int m_owner, m_rr, m_timer;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_granted = 0; m_locked = 0; m_tout = 0;
    m_owner = 0; m_rr = N - 1; m_timer = 0;
  endtask

  task automatic give(input int who);
    m_granted = 1; m_owner = who; m_rr = who;
  endtask

  task automatic model_step(input logic [N-1:0] req, exq, hw, input logic hr, halt, rstn,
                            output exp_t e);
    int win, t_next;
    bit others, rd, wr;
    logic [N-1:0] one;
    one = 1;
    if (!rstn) begin
      model_reset();
    end else begin
      win = -1;
      for (int k = 1; k <= N; k++)
        if (win < 0 && req[(m_rr + k) % N]) win = (m_rr + k) % N;
      others = 0;
      for (int i = 0; i < N; i++)
        if (i != m_owner && req[i]) others = 1;
      rd = hr && exq[m_owner] && !hw[m_owner];
      wr = hr && exq[m_owner] && hw[m_owner];
      t_next = (m_timer > 0 && !halt) ? m_timer - 1 : m_timer;
      m_tout = 0;
      if (!m_granted) begin
        if (hr && win >= 0) give(win);
      end else if (!m_locked) begin
        if (rd) begin
          m_locked = 1; t_next = LT - 1;
        end else if (hr) begin
          if (others) give(win);
          else if (!req[m_owner]) m_granted = 0;
        end
      end else begin
        if (wr) m_locked = 0;
        else if (hr && !req[m_owner]) m_locked = 0;
        else if (rd) t_next = LT - 1;
        else if (hr && m_timer == 0 && !halt) begin
          m_locked = 0; m_tout = 1;
        end
      end
      m_timer = t_next;
    end
    e.grant  = m_granted ? (one << m_owner) : '0;
    e.owner  = m_owner;
    e.locked = m_locked;
    e.tout   = m_tout;
  endtask

  task automatic cyc(input logic [N-1:0] req, exq, hw, input logic hr, halt, rstn);
    exp_t e;
    @(negedge CLK);
    REQ = req; EXREQ = exq; HWRITE_M = hw; HREADY = hr; HALTED = halt; RESETn = rstn;
    model_step(req, exq, hw, hr, halt, rstn, e);
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    cyc('0, '0, '0, 1'b1, 1'b0, 1'b0);
    cyc('0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic hold0(input int n, input int h_from, input int h_to);
    for (int i = 0; i < n; i++) cyc(2'b01, 2'b00, 2'b00, 1'b1, (i >= h_from && i < h_to), 1'b1);
  endtask

  // reset, grant master 0, then issue its exclusive read (lock entry edge)
  task automatic start_owner0();
    do_reset();
    cyc(2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    cyc(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic rand_phase(input int n, p_req, p_ex, p_wr, p_hr, p_halt, input bit sticky);
    logic [N-1:0] r, x, w;
    logic hr, ha;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < N; i++) begin
        r[i] = ($urandom_range(0, 99) < p_req);
        x[i] = ($urandom_range(0, 99) < p_ex);
        w[i] = ($urandom_range(0, 99) < p_wr);
      end
      if (sticky && m_granted) r[m_owner] = 1'b1;
      hr = ($urandom_range(0, 99) < p_hr);
      ha = ($urandom_range(0, 99) < p_halt);
      cyc(r, x, w, hr, ha, 1'b1);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (LOCKED) lock_run++;
    else if (lock_run > 0) begin
      last_lock_len = lock_run;
      lock_run = 0;
    end
    if (TIMEOUT) tout_count++;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("grant",   GRANT,   mon_e.grant);
      chk("owner",   OWNER,   mon_e.owner);
      chk("locked",  LOCKED,  mon_e.locked);
      chk("timeout", TIMEOUT, mon_e.tout);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    RESETn = 1'b0; HALTED = 1'b0; HREADY = 1'b1;
    REQ = '0; EXREQ = '0; HWRITE_M = '0;
    model_reset();
    #3;
    chk("rst_grant", GRANT, 0);
    chk("rst_owner", OWNER, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_timeout", TIMEOUT, 0);

    // single request then release
    do_reset();
    cyc(2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);

    // alternation and HREADY stall
    do_reset();
    repeat (5) cyc(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    repeat (3) cyc(2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);

    // lock held against a contender until the exclusive write
    start_owner0();
    repeat (20) cyc(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    cyc(2'b11, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1);
    repeat (3) cyc(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("lock_len_exwr", last_lock_len, 21);

    // plain timeout
    t0 = tout_count;
    start_owner0();
    hold0(135, 0, 0);
    chk("lock_len_timeout", last_lock_len, LT);
    chk("timeout_pulses", tout_count - t0, 1);

    // timeout delayed by 10 halted cycles
    start_owner0();
    hold0(145, 30, 40);
    chk("lock_len_halted", last_lock_len, LT + 10);

    // second exclusive read at cycle 100 restarts the window
    start_owner0();
    hold0(99, 0, 0);
    cyc(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
    hold0(140, 0, 0);
    chk("lock_len_reload", last_lock_len, 228);

    // exclusive write on the same edge the counter reaches its limit
    t0 = tout_count;
    start_owner0();
    hold0(127, 0, 0);
    cyc(2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1);
    hold0(3, 0, 0);
    chk("lock_len_exwr_at_zero", last_lock_len, LT);
    chk("no_timeout_on_exwr", tout_count - t0, 0);

    // asynchronous reset in the middle of a lock
    start_owner0();
    hold0(10, 0, 0);
    @(posedge CLK);
    #3;
    RESETn = 1'b0;
    #1;
    chk("async_grant", GRANT, 0);
    chk("async_owner", OWNER, 0);
    chk("async_locked", LOCKED, 0);
    chk("async_timeout", TIMEOUT, 0);
    model_reset();
    cyc('0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);

    // randomized traffic
    rand_phase(2000, 50, 30, 50, 80, 10, 1'b0);
    rand_phase(3000, 80, 2, 40, 85, 15, 1'b1);
    rand_phase(1500, 30, 40, 50, 60, 5, 1'b0);
    rand_phase(1500, 90, 1, 30, 50, 30, 1'b1);

    repeat (2) @(posedge CLK);
    #2;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
